// File: rtl/box_pkg.sv
// Shared geometry defaults, FSM state encoding and box field layout for the overlay box controller.
// Pure declarations: no latency or backpressure of its own.
package box_pkg;

  localparam int IMG_WIDTH_DEF  = 768;
  localparam int IMG_HEIGHT_DEF = 576;
  localparam int COORD_W        = 10;

  localparam int BOX_X_LSB = 30;
  localparam int BOX_Y_LSB = 20;
  localparam int BOX_W_LSB = 10;
  localparam int BOX_H_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } box_t;

  function automatic box_t unpack_box(input logic [4*COORD_W-1:0] raw);
    box_t b;
    b.x = raw[BOX_X_LSB +: COORD_W];
    b.y = raw[BOX_Y_LSB +: COORD_W];
    b.w = raw[BOX_W_LSB +: COORD_W];
    b.h = raw[BOX_H_LSB +: COORD_W];
    return b;
  endfunction

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grants are combinational from requests and the priority bit.
// Latency 0; a losing requester simply stays unserved until it wins a later cycle.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic prio_b;  // 0: requester a wins a tie

  assign gnt_a = req_a && (!prio_b || !req_b);
  assign gnt_b = req_b && ( prio_b || !req_a);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_b <= 1'b0;
    end else if (gnt_a || gnt_b) begin
      prio_b <= gnt_a;
    end
  end

endmodule

// File: rtl/box_ctrl.sv
// Overlay box controller: raster counters, det/host arbitration, shadow box committed at frame boundaries.
// Requests are accepted in 0 cycles whenever granted; box_* update only on the frame_start edge.
module box_ctrl
  import box_pkg::*;
#(
  parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
  parameter int HOLD_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        det_valid,
  output logic        det_ready,
  input  logic [39:0] det_box,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [39:0] host_box,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic [9:0]  box_w,
  output logic [9:0]  box_h,
  output logic        box_en,
  output logic        frame_start,
  output logic [9:0]  x_cnt,
  output logic [9:0]  y_cnt
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [9:0] X_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_HEIGHT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  state_t            state;
  box_t              shadow;
  box_t              req_box;
  logic              grant;
  logic              shadow_clear;
  logic              hold_expire;
  logic [HOLD_W-1:0] hold_cnt;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_a (det_valid),
    .req_b (host_valid),
    .gnt_a (det_ready),
    .gnt_b (host_ready)
  );

  assign grant        = det_ready || host_ready;
  assign req_box      = unpack_box(det_ready ? det_box : host_box);
  assign frame_start  = pix_en && (x_cnt == '0) && (y_cnt == '0);
  assign shadow_clear = (shadow.w == '0) || (shadow.h == '0);
  assign hold_expire  = frame_start && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pix_en) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 10'd1;
      end else begin
        x_cnt <= x_cnt + 10'd1;
      end
    end
  end

  // Only x/y are clamped; a zero w or h must survive so it can act as a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (grant) begin
      shadow.x <= clamp_coord(req_box.x, X_LAST);
      shadow.y <= clamp_coord(req_box.y, Y_LAST);
      shadow.w <= req_box.w;
      shadow.h <= req_box.h;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      box_x    <= '0;
      box_y    <= '0;
      box_w    <= '0;
      box_h    <= '0;
      box_en   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) state <= ST_PENDING;
        end
        ST_PENDING: begin
          if (frame_start) begin
            box_x    <= shadow.x;
            box_y    <= shadow.y;
            box_w    <= shadow.w;
            box_h    <= shadow.h;
            box_en   <= !shadow_clear;
            hold_cnt <= '0;
            // A grant landing on the commit edge is the next frame's box.
            if (grant)             state <= ST_PENDING;
            else if (shadow_clear) state <= ST_IDLE;
            else                   state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (hold_expire) begin
            box_en   <= 1'b0;
            hold_cnt <= '0;
          end else if (frame_start) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (grant)            state <= ST_PENDING;
          else if (hold_expire) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_box_ctrl.sv
// Directed bench for box_ctrl: a small-raster instance for timing/hold behaviour and a
// default-geometry instance for the full-range clamp and exact-coordinate commit.
module tb_box_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        det_valid;
  logic        host_valid;
  logic [39:0] det_box;
  logic [39:0] host_box;

  logic       det_ready, host_ready, box_en, frame_start;
  logic [9:0] box_x, box_y, box_w, box_h, x_cnt, y_cnt;
  logic       d_det_ready, d_host_ready, d_box_en, d_frame_start;
  logic [9:0] d_box_x, d_box_y, d_box_w, d_box_h, d_x_cnt, d_y_cnt;

  logic [40:0] box_all;
  logic [40:0] d_box_all;
  assign box_all   = {box_x, box_y, box_w, box_h, box_en};
  assign d_box_all = {d_box_x, d_box_y, d_box_w, d_box_h, d_box_en};

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  box_ctrl #(.IMG_WIDTH(16), .IMG_HEIGHT(4), .HOLD_FRAMES(30)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .det_valid(det_valid), .det_ready(det_ready), .det_box(det_box),
    .host_valid(host_valid), .host_ready(host_ready), .host_box(host_box),
    .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h), .box_en(box_en),
    .frame_start(frame_start), .x_cnt(x_cnt), .y_cnt(y_cnt)
  );

  box_ctrl dut_d (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .det_valid(det_valid), .det_ready(d_det_ready), .det_box(det_box),
    .host_valid(host_valid), .host_ready(d_host_ready), .host_box(host_box),
    .box_x(d_box_x), .box_y(d_box_y), .box_w(d_box_w), .box_h(d_box_h), .box_en(d_box_en),
    .frame_start(d_frame_start), .x_cnt(d_x_cnt), .y_cnt(d_y_cnt)
  );

  function automatic logic [39:0] bx(input int x, input int y, input int w, input int h);
    return {x[9:0], y[9:0], w[9:0], h[9:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance pixels until the small raster sits at (0,0), without consuming the frame_start pixel.
  task automatic seek0();
    int n = 0;
    while (!(x_cnt == 10'd0 && y_cnt == 10'd0) && n < 200) begin
      pix_en = 1'b1;
      tick();
      n++;
    end
    pix_en = 1'b0;
    chk("seek_bound", 64'(n < 200), 64'd1);
  endtask

  task automatic fs_step(input string tag);
    pix_en = 1'b1;
    #1;
    chk(tag, 64'(frame_start), 64'd1);
    tick();
    pix_en = 1'b0;
  endtask

  task automatic send(input logic is_host, input logic [39:0] b, input string tag);
    det_valid  = !is_host;
    host_valid = is_host;
    if (is_host) host_box = b;
    else         det_box  = b;
    #1;
    chk(tag, 64'({det_ready, host_ready}), is_host ? 64'b01 : 64'b10);
    tick();
    det_valid  = 1'b0;
    host_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; det_valid = 1'b0; host_valid = 1'b0;
    det_box = '0; host_box = '0;
    repeat (3) tick();
    chk("rst_box", 64'(box_all), 64'd0);
    chk("rst_box_d", 64'(d_box_all), 64'd0);
    chk("rst_cnt", 64'({x_cnt, y_cnt}), 64'd0);
    pix_en = 1'b1; tick(); pix_en = 1'b0;
    chk("rst_cnt_frozen", 64'(x_cnt), 64'd0);
    reset = 1'b0;
    tick();

    // Raster counting and frame_start
    pix_en = 1'b1; #1;
    chk("fs_first", 64'(frame_start), 64'd1);
    tick(); pix_en = 1'b0; #1;
    chk("fs_one_cycle", 64'(frame_start), 64'd0);
    chk("x_inc", 64'(x_cnt), 64'd1);
    pix_en = 1'b1; repeat (15) tick(); pix_en = 1'b0;
    chk("x_wrap", 64'({x_cnt, y_cnt}), 64'({10'd0, 10'd1}));
    pix_en = 1'b1; #1;
    chk("fs_not_line", 64'(frame_start), 64'd0);
    pix_en = 1'b0;

    // Mid-frame detector box waits for the frame boundary
    send(1'b0, bx(5, 2, 40, 60), "c_rdy");
    chk("c_hold_mid", 64'(box_all), 64'd0);
    seek0();
    chk("c_hold_pre", 64'(box_all), 64'd0);
    fs_step("c_fs");
    chk("c_commit", 64'(box_all), 64'({bx(5, 2, 40, 60), 1'b1}));

    // Round-robin with both requesters held high
    send(1'b1, bx(3, 1, 4, 4), "d_host_only");
    det_valid = 1'b1; host_valid = 1'b1; det_box = bx(1, 1, 2, 2);
    for (int i = 0; i < 4; i++) begin
      host_box = bx(10 + i, 2, 5 + i, 6);
      #1;
      chk("d_rr", 64'({det_ready, host_ready}), (i % 2 == 0) ? 64'b10 : 64'b01);
      tick();
    end
    det_valid = 1'b0; host_valid = 1'b0;
    chk("d_still_old", 64'(box_all), 64'({bx(5, 2, 40, 60), 1'b1}));
    seek0();
    fs_step("d_fs");
    chk("d_commit_last_host", 64'(box_all), 64'({bx(13, 2, 8, 6), 1'b1}));

    // Grant on the frame_start cycle commits the older shadow first
    send(1'b0, bx(4, 1, 3, 3), "e_rdy");
    seek0();
    pix_en = 1'b1; host_valid = 1'b1; host_box = bx(6, 0, 2, 5); #1;
    chk("e_fs_grant", 64'({frame_start, det_ready, host_ready}), 64'b101);
    tick(); pix_en = 1'b0; host_valid = 1'b0;
    chk("e_commit_prev", 64'(box_all), 64'({bx(4, 1, 3, 3), 1'b1}));
    seek0();
    fs_step("e_fs2");
    chk("e_commit_new", 64'(box_all), 64'({bx(6, 0, 2, 5), 1'b1}));

    // Zero width or height clears the overlay
    send(1'b0, bx(7, 1, 0, 5), "f_rdy");
    seek0(); fs_step("f_fs");
    chk("f_clear_w", 64'(box_en), 64'd0);
    send(1'b1, bx(2, 2, 3, 3), "f_rdy2");
    seek0(); fs_step("f_fs2");
    chk("f_reopen", 64'(box_all), 64'({bx(2, 2, 3, 3), 1'b1}));
    send(1'b0, bx(1, 1, 3, 0), "f_rdy3");
    seek0(); fs_step("f_fs3");
    chk("f_clear_h", 64'(box_en), 64'd0);

    // Hold timeout after 30 frames without a refresh
    send(1'b1, bx(8, 3, 4, 4), "g_rdy");
    seek0(); fs_step("g_fs");
    chk("g_commit", 64'(box_all), 64'({bx(8, 3, 4, 4), 1'b1}));
    for (int i = 1; i <= 30; i++) begin
      seek0();
      fs_step("g_fs_n");
      chk("g_hold", 64'(box_en), 64'(i < 30));
    end
    chk("g_keep_coords", 64'(box_x), 64'd8);

    // Reset mid-frame discards the pending box and the priority pointer
    pix_en = 1'b1; repeat (5) tick(); pix_en = 1'b0;
    send(1'b0, bx(9, 1, 5, 5), "h_rdy");
    reset = 1'b1; #1;
    chk("h_rst_out", 64'({box_all, x_cnt, y_cnt, frame_start}), 64'd0);
    tick(); reset = 1'b0; tick();
    fs_step("h_fs");
    chk("h_no_commit", 64'(box_all), 64'd0);
    det_valid = 1'b1; host_valid = 1'b1; #1;
    chk("h_ptr_rst", 64'({det_ready, host_ready}), 64'b10);
    tick(); det_valid = 1'b0; host_valid = 1'b0;

    // Default geometry: exact coordinates and full-range clamp
    reset = 1'b1; tick(); reset = 1'b0; tick();
    det_valid = 1'b1; det_box = bx(100, 200, 40, 60); #1;
    chk("i_d_rdy", 64'({d_det_ready, d_host_ready}), 64'b10);
    tick(); det_valid = 1'b0;
    repeat (3) tick();
    chk("i_wait", 64'(d_box_all), 64'd0);
    chk("i_d_cnt", 64'({d_x_cnt, d_y_cnt}), 64'd0);
    pix_en = 1'b1; #1;
    chk("i_dfs", 64'(d_frame_start), 64'd1);
    tick(); pix_en = 1'b0;
    chk("i_commit_d", 64'(d_box_all), 64'({bx(100, 200, 40, 60), 1'b1}));
    chk("i_commit_s", 64'(box_all), 64'({bx(15, 3, 40, 60), 1'b1}));
    reset = 1'b1; tick(); reset = 1'b0; tick();
    send(1'b1, bx(900, 700, 12, 34), "i_host_rdy");
    fs_step("i_fs2");
    chk("i_clamp_d", 64'(d_box_all), 64'({bx(767, 575, 12, 34), 1'b1}));
    chk("i_clamp_s", 64'(box_all), 64'({bx(15, 3, 12, 34), 1'b1}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
